// File: rtl/lock_pkg.sv
// Shared constants for the lock input conditioner.
//   DEBOUNCE_CYCLES_DEF : default debounce length (10 ms at 50 MHz)
//   CNT_W / cnt_t       : debounce counter width and type
//   NUM_CH, ARRIVE..OPORT : channel count and channel indices
//   CONFLICT_MAX        : saturation value of the conflict counter
package lock_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int          CNT_W               = 20;
  localparam int          NUM_CH              = 6;

  localparam int ARRIVE = 0;
  localparam int DEPART = 1;
  localparam int FILL   = 2;
  localparam int DRAIN  = 3;
  localparam int IPORT  = 4;
  localparam int OPORT  = 5;

  localparam logic [7:0] CONFLICT_MAX = 8'hFF;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/lock_input_conditioner_debounce_channel.sv
// One conditioned input: 2-flop synchronizer, debounced level and a
// single-cycle pulse on the first cycle the level is high.
//   clock, reset : system clock, synchronous active-high reset
//   raw_i        : asynchronous raw switch level
//   level_o      : debounced level
//   rise_o       : high for the first cycle level_o is 1
module debounce_channel
  import lock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam cnt_t TERM = cnt_t'(DEBOUNCE_CYCLES - 1);

  logic sync1_q;
  logic sync2_q;
  logic s_q;
  logic s_d;
  logic s_prev_q;
  cnt_t cnt_q;
  cnt_t cnt_d;

  // Any cycle that agrees with the stable level restarts the run, so a
  // single-cycle bounce discards all progress.
  always_comb begin
    s_d   = s_q;
    cnt_d = '0;
    if (sync2_q != s_q) begin
      if (cnt_q == TERM) begin
        s_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      s_q      <= s_d;
      s_prev_q <= s_q;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = s_q;
  assign rise_o  = s_q & ~s_prev_q;

endmodule

// File: rtl/lock_input_conditioner.sv
// Conditions six lock switch/key inputs into command pulses and port levels
// for the interlock controller. Fill and drain are mutually exclusive: a
// rising command while the other is active is rejected and counted.
//   clock, reset          : system clock, synchronous active-high reset
//   raw_*                 : asynchronous active-high switch levels
//   arrive/depart/fill/drain : one-cycle command pulses
//   iport/oport           : debounced port-open levels
//   conflict              : one-cycle pulse on a rejected fill/drain
//   port_fault            : both ports open
//   conflict_count        : saturating conflict count
module lock_input_conditioner
  import lock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_arrive,
  input  logic       raw_depart,
  input  logic       raw_fill,
  input  logic       raw_drain,
  input  logic       raw_iport,
  input  logic       raw_oport,
  output logic       arrive,
  output logic       depart,
  output logic       fill,
  output logic       drain,
  output logic       iport,
  output logic       oport,
  output logic       conflict,
  output logic       port_fault,
  output logic [7:0] conflict_count
);

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] rise;
  logic              fill_block;
  logic              drain_block;
  logic [7:0]        conflict_count_q;
  logic [7:0]        conflict_count_d;
  logic              unused_bits;

  assign raw_vec[ARRIVE] = raw_arrive;
  assign raw_vec[DEPART] = raw_depart;
  assign raw_vec[FILL]   = raw_fill;
  assign raw_vec[DRAIN]  = raw_drain;
  assign raw_vec[IPORT]  = raw_iport;
  assign raw_vec[OPORT]  = raw_oport;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clock  (clock),
      .reset  (reset),
      .raw_i  (raw_vec[g]),
      .level_o(level[g]),
      .rise_o (rise[g])
    );
  end

  // Gating looks at the other channel's current level, so simultaneous
  // rises block each other and still yield only one conflict cycle.
  assign fill_block  = rise[FILL]  & level[DRAIN];
  assign drain_block = rise[DRAIN] & level[FILL];

  assign arrive     = rise[ARRIVE];
  assign depart     = rise[DEPART];
  assign fill       = rise[FILL]  & ~level[DRAIN];
  assign drain      = rise[DRAIN] & ~level[FILL];
  assign conflict   = fill_block | drain_block;
  assign iport      = level[IPORT];
  assign oport      = level[OPORT];
  assign port_fault = level[IPORT] & level[OPORT];

  always_comb begin
    conflict_count_d = conflict_count_q;
    if (conflict && (conflict_count_q != CONFLICT_MAX)) begin
      conflict_count_d = conflict_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_count_q <= 8'd0;
    end else begin
      conflict_count_q <= conflict_count_d;
    end
  end

  assign conflict_count = conflict_count_q;

  // Levels of the command channels and pulses of the port channels have
  // no consumer.
  assign unused_bits = ^{level[ARRIVE], level[DEPART], rise[IPORT], rise[OPORT]};

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Scoreboard bench for lock_input_conditioner with DEBOUNCE_CYCLES = 4.
// A reference model predicts every cycle's outputs from a history of raw
// samples; a monitor compares them. Directed scenarios add spot checks.
module tb_lock_input_conditioner;

  localparam int DEB  = 4;
  localparam int OBSN = 8192;

  localparam logic [5:0] M_ARR = 6'b000001;
  localparam logic [5:0] M_FIL = 6'b000100;
  localparam logic [5:0] M_DRN = 6'b001000;
  localparam logic [5:0] M_IPT = 6'b010000;
  localparam logic [5:0] M_OPT = 6'b100000;

  localparam int B_ARR  = 15;
  localparam int B_FIL  = 13;
  localparam int B_DRN  = 12;
  localparam int B_CONF = 9;
  localparam int B_PF   = 8;

  logic clock = 1'b0;
  logic reset;
  logic raw_arrive, raw_depart, raw_fill, raw_drain, raw_iport, raw_oport;
  logic arrive, depart, fill, drain, iport, oport, conflict, port_fault;
  logic [7:0] conflict_count;
  logic [15:0] dut_vec;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  logic [15:0] expq[$];
  logic [15:0] obs[0:OBSN-1];

  lock_input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock         (clock),
    .reset         (reset),
    .raw_arrive    (raw_arrive),
    .raw_depart    (raw_depart),
    .raw_fill      (raw_fill),
    .raw_drain     (raw_drain),
    .raw_iport     (raw_iport),
    .raw_oport     (raw_oport),
    .arrive        (arrive),
    .depart        (depart),
    .fill          (fill),
    .drain         (drain),
    .iport         (iport),
    .oport         (oport),
    .conflict      (conflict),
    .port_fault    (port_fault),
    .conflict_count(conflict_count)
  );

  assign dut_vec = {arrive, depart, fill, drain, iport, oport, conflict,
                    port_fault, conflict_count};

  always #5 clock = ~clock;

  // Reference model: a level changes once the last DEB synchronized samples
  // all disagree with it; the synchronized sample is the raw value two
  // edges earlier (zero until that many samples exist after reset).
  bit   s_m[6];
  bit   prev_m[6];
  bit   rawh[6][$];
  bit   synch[6][$];
  bit   all_diff;
  bit   conf_m;
  bit   rf, rd;
  int   cnt_m;
  logic [5:0]  raw_s;
  logic [15:0] expv;

  initial begin
    conf_m = 1'b0;
    cnt_m  = 0;
    forever begin
      @(posedge clock);
      raw_s = {raw_oport, raw_iport, raw_drain, raw_fill, raw_depart, raw_arrive};
      if (reset) begin
        for (int c = 0; c < 6; c++) begin
          s_m[c] = 1'b0;
          prev_m[c] = 1'b0;
          rawh[c].delete();
          synch[c].delete();
        end
        cnt_m  = 0;
        conf_m = 1'b0;
      end else begin
        if (conf_m && cnt_m < 255) cnt_m++;
        for (int c = 0; c < 6; c++) begin
          prev_m[c] = s_m[c];
          rawh[c].push_back(raw_s[c]);
          if (rawh[c].size() > 3) void'(rawh[c].pop_front());
          synch[c].push_back(rawh[c].size() == 3 ? rawh[c][0] : 1'b0);
          if (synch[c].size() > DEB) void'(synch[c].pop_front());
          all_diff = (synch[c].size() == DEB);
          for (int i = 0; i < synch[c].size(); i++)
            if (synch[c][i] == s_m[c]) all_diff = 1'b0;
          if (all_diff) s_m[c] = ~s_m[c];
        end
      end
      rf = s_m[2] & ~prev_m[2];
      rd = s_m[3] & ~prev_m[3];
      conf_m = (rf & s_m[3]) | (rd & s_m[2]);
      expv = {s_m[0] & ~prev_m[0], s_m[1] & ~prev_m[1], rf & ~s_m[3], rd & ~s_m[2],
              s_m[4], s_m[5], conf_m, s_m[4] & s_m[5], 8'(cnt_m)};
      expq.push_back(expv);
      edge_cnt++;
    end
  end

  // Monitor: every cycle presents outputs; compare against the queue.
  logic [15:0] exp_pop;
  initial begin
    forever begin
      @(negedge clock);
      if (edge_cnt > 0) begin
        if (edge_cnt <= OBSN) obs[edge_cnt-1] = dut_vec;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty edge=%0d got=%h", edge_cnt - 1, dut_vec);
        end else begin
          exp_pop = expq.pop_front();
          if (dut_vec !== exp_pop) begin
            errors++;
            $display("FAIL outputs edge=%0d got=%h exp=%h", edge_cnt - 1, dut_vec, exp_pop);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic set_raw(input logic [5:0] v);
    {raw_oport, raw_iport, raw_drain, raw_fill, raw_depart, raw_arrive} = v;
  endtask

  function automatic int obs_bit(input int idx, input int b);
    logic [15:0] w;
    if (idx < 0 || idx >= OBSN) return -1;
    w = obs[idx];
    return int'(w[b]);
  endfunction

  function automatic int pulses(input int lo, input int hi, input int b);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (obs_bit(i, b) == 1) n++;
    return n;
  endfunction

  int base;
  logic [5:0] rnd;
  logic [15:0] w;

  initial begin
    reset = 1'b1;
    set_raw(6'b0);
    cyc(3);
    reset = 1'b0;
    w = obs[edge_cnt-1];
    chk("reset_outputs", int'(w), 0);

    // single clean fill press
    base = edge_cnt;
    set_raw(M_FIL);
    cyc(12);
    chk("fill_before", obs_bit(base + 4, B_FIL), 0);
    chk("fill_pulse", obs_bit(base + 5, B_FIL), 1);
    chk("fill_after", obs_bit(base + 6, B_FIL), 0);
    chk("fill_pulse_count", pulses(base, base + 11, B_FIL), 1);
    chk("fill_no_conflict", pulses(base, base + 11, B_CONF), 0);
    set_raw(6'b0);
    cyc(12);

    // bouncing arrive
    base = edge_cnt;
    set_raw(M_ARR); cyc(1);
    set_raw(6'b0);  cyc(1);
    set_raw(M_ARR); cyc(1);
    set_raw(6'b0);  cyc(1);
    set_raw(M_ARR); cyc(12);
    chk("arrive_pulse_count", pulses(base, base + 15, B_ARR), 1);
    chk("arrive_pulse_edge9", obs_bit(base + 9, B_ARR), 1);
    set_raw(6'b0);
    cyc(12);

    // simultaneous fill and drain
    base = edge_cnt;
    set_raw(M_FIL | M_DRN);
    cyc(10);
    chk("sim_fill_none", pulses(base, base + 9, B_FIL), 0);
    chk("sim_drain_none", pulses(base, base + 9, B_DRN), 0);
    chk("sim_conflict_edge5", obs_bit(base + 5, B_CONF), 1);
    chk("sim_conflict_count", pulses(base, base + 9, B_CONF), 1);
    w = obs[base + 5];
    chk("sim_cnt_before", int'(w[7:0]), 0);
    w = obs[base + 6];
    chk("sim_cnt_after", int'(w[7:0]), 1);
    set_raw(6'b0);
    cyc(12);

    // both ports open, then oport closes
    base = edge_cnt;
    set_raw(M_IPT | M_OPT);
    cyc(20);
    set_raw(M_IPT);
    cyc(8);
    chk("pf_edge4", obs_bit(base + 4, B_PF), 0);
    chk("pf_edge5", obs_bit(base + 5, B_PF), 1);
    chk("pf_edge24", obs_bit(base + 24, B_PF), 1);
    chk("pf_edge25", obs_bit(base + 25, B_PF), 0);
    set_raw(6'b0);
    cyc(10);

    // reset in the middle of a drain debounce
    base = edge_cnt;
    set_raw(M_DRN);
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(12);
    w = obs[base + 3];
    chk("midreset_outputs", int'(w), 0);
    chk("midreset_no_early", pulses(base, base + 8, B_DRN), 0);
    chk("midreset_pulse_edge9", obs_bit(base + 9, B_DRN), 1);

    // 260 rejected fills with drain held: counter saturates
    base = edge_cnt;
    for (int k = 0; k < 260; k++) begin
      set_raw(M_FIL | M_DRN);
      cyc(7);
      set_raw(M_DRN);
      cyc(7);
    end
    cyc(2);
    chk("sat_conflicts", pulses(base, edge_cnt - 2, B_CONF), 260);
    chk("sat_no_fill", pulses(base, edge_cnt - 2, B_FIL), 0);
    w = obs[edge_cnt - 2];
    chk("sat_count", int'(w[7:0]), 255);
    set_raw(6'b0);
    cyc(12);

    // random bouncing on all channels with occasional reset
    rnd = 6'b0;
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < 6; c++)
        if ($urandom_range(0, 7) == 0) rnd[c] = ~rnd[c];
      reset = ($urandom_range(0, 599) == 0);
      set_raw(rnd);
      cyc(1);
    end
    reset = 1'b0;
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout edge=%0d", edge_cnt);
    $fatal(1, "timeout");
  end

endmodule
